// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, datapath mux codes, opcodes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALU_WB_R = 4'd9,
    S_ALU_WB_I = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;
  localparam logic [1:0] ALU_OPCODE = 2'd3;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Post-decode dispatch; unknown opcodes land in HALT.
  function automatic state_t decode_dispatch(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:                     nxt = S_MEM_ADDR;
      OP_RTYPE:                         nxt = S_EXEC_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_EXEC_I;
      OP_BEQ, OP_BNE:                   nxt = S_BRANCH;
      OP_J:                             nxt = S_JUMP;
      default:                          nxt = S_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_watchdog.sv
// Memory wait-state watchdog: counts consecutive unanswered request cycles and flags the limit.
module multicycle_control_watchdog #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam int unsigned LIMIT = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;

  logic [CW-1:0] wait_cnt;

  // The current wait cycle is the MAX_WAIT-th one; a same-cycle ready still wins.
  assign expire = (MAX_WAIT != 0) && req && !ready && (wait_cnt == CW'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (clear || ready || !req) begin
      wait_cnt <= '0;
    end else if (MAX_WAIT != 0) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: sequences one shared variable-latency memory and the datapath.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic             mem_phase_c;
  logic             expire_c;
  logic             wd_clear_c;
  logic             set_illegal_c;
  logic             set_timeout_c;
  logic             illegal_q, timeout_q;
  logic [CNT_W-1:0] retired_q;

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

  // Request states are decoded straight from the register so the watchdog sees no comb loop.
  assign mem_phase_c = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wd_clear_c  = (state_d != state_q);

  multicycle_control_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .req    (mem_phase_c),
    .ready  (mem_ready),
    .clear  (wd_clear_c),
    .expire (expire_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    set_illegal_c = 1'b0;
    set_timeout_c = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (expire_c) begin
          set_timeout_c = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_DECODE: begin
        alu_src_b     = SRCB_IMM_SH2;
        state_d       = decode_dispatch(opcode);
        set_illegal_c = (state_d == S_HALT);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (expire_c) begin
          set_timeout_c = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (expire_c) begin
          set_timeout_c = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALU_WB_R;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OPCODE;
        state_d   = S_ALU_WB_I;
      end
      S_ALU_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ALU_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write   = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Sticky halt causes and the retired-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (set_illegal_c) illegal_q <= 1'b1;
      if (set_timeout_c) timeout_q <= 1'b1;
      if (instr_done)    retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios, then a random instruction stream
// checked per instruction against latency/strobe totals derived from the instruction class.
`define CHK(t, o, e) chk(t, 32'(o), 32'(e))

module tb_multicycle_control;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 4;

  localparam logic [5:0] OPC_R    = 6'h00;
  localparam logic [5:0] OPC_J    = 6'h02;
  localparam logic [5:0] OPC_BEQ  = 6'h04;
  localparam logic [5:0] OPC_BNE  = 6'h05;
  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SLTI = 6'h0A;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2B;
  localparam logic [5:0] OPC_BAD  = 6'h3F;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3, ST_MEM_RD = 4;
  localparam int ST_MEM_WB = 5, ST_MEM_WR = 6, ST_EXEC_R = 7, ST_ALU_WB_R = 9;
  localparam int ST_BRANCH = 11, ST_JUMP = 12, ST_HALT = 13;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [5:0]       opcode = 6'h00;
  logic             alu_zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic [3:0]       state;
  logic             mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic [1:0]       pc_src, alu_src_b, alu_op;
  logic             alu_src_a, reg_write, reg_dst, mem_to_reg, instr_done;
  logic [CNT_W-1:0] retired;
  logic             illegal, timeout;

  int errors = 0;
  int checks = 0;

  logic [5:0] legal_ops [10] = '{OPC_R, OPC_J, OPC_BEQ, OPC_BNE, OPC_ADDI,
                                 OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_LW, OPC_SW};

  always #5 clk = ~clk;

  multicycle_control #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .alu_zero     (alu_zero),
    .mem_ready    (mem_ready),
    .state        (state),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .instr_done   (instr_done),
    .retired      (retired),
    .illegal      (illegal),
    .timeout      (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic z, input logic rdy);
    opcode    = op;
    alu_zero  = z;
    mem_ready = rdy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic [5:0] op;
    logic       z;
    int         fw, dw, left, lat, base, ret_model, e_lat;
    int         c_req, c_we, c_rw, c_dst, c_m2r, c_pcw, c_irw, c_done;
    int         e_req, e_we, e_rw, e_dst, e_m2r, e_pcw;
    bit         is_mem, done;

    // Reset state
    #2;
    checks++;
    if (state !== 4'(ST_IDLE)) begin
      errors++;
      $display("FAIL rst_state observed=%0h expected=%0h", state, ST_IDLE);
    end
    `CHK("rst_strobes", {mem_req, mem_we, ir_write, pc_write, reg_write, instr_done}, 0);
    `CHK("rst_retired", retired, 0);
    `CHK("rst_flags", {illegal, timeout}, 0);

    // R-type with zero-wait memory
    @(posedge clk); #1;
    rst = 1'b1;
    drive(OPC_R, 1'b0, 1'b1);
    `CHK("r_idle", state, ST_IDLE);
    cyc();
    `CHK("r_fetch_state", state, ST_FETCH);
    `CHK("r_fetch_strobes", {mem_req, mem_addr_sel, ir_write, pc_write}, 4'b1011);
    `CHK("r_fetch_alu", {alu_src_a, alu_src_b, alu_op, pc_src}, 7'b0_01_00_00);
    cyc();
    `CHK("r_decode", {state, alu_src_a, alu_src_b, alu_op}, {4'(ST_DECODE), 5'b0_11_00});
    cyc();
    `CHK("r_exec", {state, alu_src_a, alu_src_b, alu_op}, {4'(ST_EXEC_R), 5'b1_00_10});
    cyc();
    `CHK("r_wb", {state, reg_write, reg_dst, mem_to_reg, instr_done}, {4'(ST_ALU_WB_R), 4'b1101});
    cyc();
    `CHK("r_back_fetch", state, ST_FETCH);
    `CHK("r_retired", retired, 1);

    // LW with three data wait cycles
    drive(OPC_LW, 1'b0, 1'b1);
    cyc();
    `CHK("lw_decode", state, ST_DECODE);
    cyc();
    `CHK("lw_addr", {state, alu_src_a, alu_src_b, alu_op}, {4'(ST_MEM_ADDR), 5'b1_10_00});
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(OPC_LW, 1'b0, 1'(i == 3));
      `CHK("lw_rd_state", state, ST_MEM_RD);
      `CHK("lw_rd_req", {mem_req, mem_addr_sel}, 2'b11);
      `CHK("lw_rd_quiet", {mem_we, ir_write, pc_write, reg_write, instr_done}, 0);
    end
    cyc();
    `CHK("lw_wb", {state, reg_write, reg_dst, mem_to_reg, instr_done}, {4'(ST_MEM_WB), 4'b1011});
    cyc();
    `CHK("lw_back_fetch", state, ST_FETCH);
    `CHK("lw_retired", retired, 2);

    // BEQ taken, BNE not taken
    drive(OPC_BEQ, 1'b1, 1'b1);
    cyc();
    cyc();
    `CHK("beq_state", state, ST_BRANCH);
    `CHK("beq_ctl", {pc_write, pc_src, alu_op, alu_src_a, instr_done}, 7'b1_01_01_1_1);
    cyc();
    `CHK("beq_done", {4'(state), retired}, {4'(ST_FETCH), 4'd3});
    drive(OPC_BNE, 1'b1, 1'b1);
    cyc();
    cyc();
    `CHK("bne_ctl", {4'(state), pc_write, instr_done}, {4'(ST_BRANCH), 2'b01});
    cyc();
    `CHK("bne_done", {4'(state), retired}, {4'(ST_FETCH), 4'd4});

    // Illegal opcode halts until reset
    drive(OPC_BAD, 1'b0, 1'b1);
    cyc();
    cyc();
    `CHK("ill_halt", {4'(state), illegal, timeout}, {4'(ST_HALT), 2'b10});
    for (int i = 0; i < 20; i++) begin
      cyc();
      drive(6'($urandom), 1'($urandom), 1'($urandom));
      `CHK("ill_quiet", {4'(state), mem_req, mem_we, ir_write, pc_write, reg_write, instr_done},
           {4'(ST_HALT), 6'b0});
    end
    #3 rst = 1'b0;
    #1;
    `CHK("ill_reset", {4'(state), illegal, retired}, {4'(ST_IDLE), 1'b0, 4'd0});

    // Fetch watchdog expiry
    @(posedge clk); #1;
    rst = 1'b1;
    drive(OPC_R, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(OPC_R, 1'b0, 1'b0);
      `CHK("wd_wait", {4'(state), mem_req}, {4'(ST_FETCH), 1'b1});
    end
    cyc();
    `CHK("wd_halt", {4'(state), timeout, mem_req, illegal}, {4'(ST_HALT), 3'b100});
    rst = 1'b0;
    #1;
    `CHK("wd_reset", {4'(state), timeout}, {4'(ST_IDLE), 1'b0});

    // Ready arriving on the limit cycle wins; followed by a jump
    @(posedge clk); #1;
    rst = 1'b1;
    drive(OPC_J, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(OPC_J, 1'b0, 1'(i == 3));
      `CHK("wd_race_fetch", state, ST_FETCH);
    end
    cyc();
    `CHK("wd_race_decode", {4'(state), timeout}, {4'(ST_DECODE), 1'b0});
    cyc();
    `CHK("j_ctl", {4'(state), pc_write, pc_src, instr_done}, {4'(ST_JUMP), 4'b1101});
    cyc();
    `CHK("j_done", {4'(state), retired}, {4'(ST_FETCH), 4'd1});

    // Reset landing in the middle of a store
    drive(OPC_SW, 1'b0, 1'b1);
    cyc();
    cyc();
    cyc();
    drive(OPC_SW, 1'b0, 1'b0);
    `CHK("sw_wr", {4'(state), mem_req, mem_we, mem_addr_sel, instr_done}, {4'(ST_MEM_WR), 4'b1110});
    #2 rst = 1'b0;
    #1;
    `CHK("sw_async_rst", {4'(state), mem_req, mem_we, retired}, {4'(ST_IDLE), 2'b00, 4'd0});
    #2 rst = 1'b1;
    #1;
    `CHK("rel_idle", {4'(state), mem_req}, {4'(ST_IDLE), 1'b0});
    @(posedge clk); #1;
    `CHK("rel_fetch", {4'(state), mem_req}, {4'(ST_FETCH), 1'b1});

    // Random instruction stream against per-instruction totals
    ret_model = 0;
    for (int n = 0; n < 40; n++) begin
      op     = legal_ops[$urandom_range(0, 9)];
      z      = 1'($urandom_range(0, 1));
      fw     = int'($urandom_range(0, MAX_WAIT - 1));
      dw     = int'($urandom_range(0, MAX_WAIT - 1));
      is_mem = (op == OPC_LW) || (op == OPC_SW);
      if (op == OPC_LW) base = 5;
      else if (op == OPC_R || op == OPC_SW || op == OPC_ADDI || op == OPC_ANDI ||
               op == OPC_ORI || op == OPC_SLTI) base = 4;
      else base = 3;
      e_lat = base + fw + (is_mem ? dw : 0);
      e_req = fw + 1 + (is_mem ? dw + 1 : 0);
      e_we  = (op == OPC_SW) ? dw + 1 : 0;
      e_rw  = (op == OPC_LW || base == 4 && op != OPC_SW) ? 1 : 0;
      e_dst = (op == OPC_R) ? 1 : 0;
      e_m2r = (op == OPC_LW) ? 1 : 0;
      e_pcw = 1 + ((op == OPC_J) ? 1 : 0) +
              (((op == OPC_BEQ && z) || (op == OPC_BNE && !z)) ? 1 : 0);
      c_req = 0; c_we = 0; c_rw = 0; c_dst = 0; c_m2r = 0; c_pcw = 0; c_irw = 0; c_done = 0;
      left = fw;
      lat  = 0;
      done = 1'b0;
      opcode   = op;
      alu_zero = z;
      while (!done && lat < 24) begin
        lat++;
        if (mem_req) begin
          if (left > 0) begin
            mem_ready = 1'b0;
            left--;
          end else begin
            mem_ready = 1'b1;
            left = dw;
          end
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        #1;
        c_req  += int'(mem_req);
        c_we   += int'(mem_we & mem_req);
        c_rw   += int'(reg_write);
        c_dst  += int'(reg_write & reg_dst);
        c_m2r  += int'(reg_write & mem_to_reg);
        c_pcw  += int'(pc_write);
        c_irw  += int'(ir_write);
        c_done += int'(instr_done);
        if (instr_done) done = 1'b1;
        else cyc();
      end
      cyc();
      ret_model++;
      checks++;
      if (lat != e_lat) begin
        errors++;
        $display("FAIL rnd_latency observed=%0d expected=%0d", lat, e_lat);
      end
      `CHK("rnd_mem_req", c_req, e_req);
      `CHK("rnd_mem_we", c_we, e_we);
      `CHK("rnd_reg_write", c_rw, e_rw);
      `CHK("rnd_reg_dst", c_dst, e_dst);
      `CHK("rnd_mem_to_reg", c_m2r, e_m2r);
      `CHK("rnd_pc_write", c_pcw, e_pcw);
      `CHK("rnd_ir_write", c_irw, 1);
      checks++;
      if (c_done != 1) begin
        errors++;
        $display("FAIL rnd_done observed=%0d expected=1", c_done);
      end
      checks++;
      if (retired !== CNT_W'(ret_model)) begin
        errors++;
        $display("FAIL rnd_retired observed=%0d expected=%0d", retired, CNT_W'(ret_model));
      end
      `CHK("rnd_next_fetch", {4'(state), illegal, timeout}, {4'(ST_FETCH), 2'b00});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
